// File: rtl/barcode_seq.sv
`default_nettype none
// ============================================================================
// Module   : barcode_seq
// Purpose  : Power-up, PWM bit-serialise and power-down sequencer for the
//            iCE40UP barcode/IR current-sink driver.
// Revision : 1.0
// ============================================================================
module barcode_seq #(
  parameter int WARMUP_CYCLES   = 1200,
  parameter int COOLDOWN_CYCLES = 16,
  parameter int PAT_W           = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     START,
  input  logic                     ABORT,
  input  logic [PAT_W-1:0]         PATTERN,
  input  logic [$clog2(PAT_W):0]   NBITS,
  input  logic [15:0]              BIT_PERIOD,
  input  logic [7:0]               DUTY,
  input  logic [3:0]               REPEAT,
  output logic                     BUSY,
  output logic                     DONE,
  output logic                     CURREN,
  output logic                     BARCODEEN,
  output logic                     BARCODEPWM
);

  localparam int NB_W    = $clog2(PAT_W) + 1;
  localparam int CNT_MAX = (WARMUP_CYCLES > COOLDOWN_CYCLES) ? WARMUP_CYCLES : COOLDOWN_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] WARM_LOAD = CNT_W'(WARMUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOLDOWN_CYCLES - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WARMUP   = 3'd1;
  localparam logic [2:0] S_ENABLE   = 3'd2;
  localparam logic [2:0] S_SEND     = 3'd3;
  localparam logic [2:0] S_COOLDOWN = 3'd4;

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [PAT_W-1:0] sr, sr_nxt;
  logic [15:0]      per_cnt, per_nxt;
  logic [7:0]       pwm_cnt, pwm_nxt;
  logic [NB_W-1:0]  bits_left, bits_nxt;
  logic [3:0]       rep_left, rep_nxt;
  logic             done_nxt;
  logic             take;

  // Values captured at START; they stay frozen for the whole sequence.
  logic [PAT_W-1:0] pat_l;
  logic [NB_W-1:0]  nbits_l;
  logic [15:0]      per_m1_l;
  logic [7:0]       duty_l;
  logic [3:0]       rep_l;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sr_nxt    = sr;
    per_nxt   = per_cnt;
    pwm_nxt   = pwm_cnt;
    bits_nxt  = bits_left;
    rep_nxt   = rep_left;
    done_nxt  = 1'b0;
    take      = 1'b0;

    case (state)
      S_IDLE: begin
        if (START && !ABORT && (NBITS != '0)) begin
          state_nxt = S_WARMUP;
          cnt_nxt   = WARM_LOAD;
          take      = 1'b1;
        end
      end
      S_WARMUP: begin
        if (cnt == '0) state_nxt = S_ENABLE;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      S_ENABLE: begin
        state_nxt = S_SEND;
        sr_nxt    = pat_l;
        per_nxt   = '0;
        pwm_nxt   = '0;
        bits_nxt  = nbits_l;
        rep_nxt   = rep_l;
      end
      S_SEND: begin
        if (per_cnt == per_m1_l) begin
          per_nxt = '0;
          pwm_nxt = '0;
          if (bits_left == NB_W'(1)) begin
            if (rep_left != '0) begin
              rep_nxt  = rep_left - 4'd1;
              sr_nxt   = pat_l;
              bits_nxt = nbits_l;
            end else begin
              state_nxt = S_COOLDOWN;
              cnt_nxt   = COOL_LOAD;
            end
          end else begin
            sr_nxt   = sr << 1;
            bits_nxt = bits_left - NB_W'(1);
          end
        end else begin
          per_nxt = per_cnt + 16'd1;
          pwm_nxt = pwm_cnt + 8'd1;  // wraps 255->0 inside long bits
        end
      end
      S_COOLDOWN: begin
        if (cnt == '0) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (ABORT && (state != S_IDLE)) begin
      state_nxt = S_IDLE;
      done_nxt  = 1'b0;
    end

    if (state_nxt == S_IDLE) begin
      cnt_nxt  = '0;
      sr_nxt   = '0;
      per_nxt  = '0;
      pwm_nxt  = '0;
      bits_nxt = '0;
      rep_nxt  = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      cnt        <= '0;
      sr         <= '0;
      per_cnt    <= '0;
      pwm_cnt    <= '0;
      bits_left  <= '0;
      rep_left   <= '0;
      pat_l      <= '0;
      nbits_l    <= '0;
      per_m1_l   <= '0;
      duty_l     <= '0;
      rep_l      <= '0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      CURREN     <= 1'b0;
      BARCODEEN  <= 1'b0;
      BARCODEPWM <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      sr        <= sr_nxt;
      per_cnt   <= per_nxt;
      pwm_cnt   <= pwm_nxt;
      bits_left <= bits_nxt;
      rep_left  <= rep_nxt;
      if (take) begin
        pat_l    <= PATTERN;
        nbits_l  <= NBITS;
        per_m1_l <= (BIT_PERIOD == 16'd0) ? 16'd0 : (BIT_PERIOD - 16'd1);
        duty_l   <= DUTY;
        rep_l    <= REPEAT;
      end
      // Outputs are registered from next-state values so they line up with the state.
      BUSY       <= (state_nxt != S_IDLE);
      DONE       <= done_nxt;
      CURREN     <= (state_nxt != S_IDLE);
      BARCODEEN  <= (state_nxt == S_ENABLE) || (state_nxt == S_SEND);
      BARCODEPWM <= (state_nxt == S_SEND) && sr_nxt[PAT_W-1] && (pwm_nxt < duty_l);
    end
  end

endmodule
`default_nettype wire

// File: doc/barcode_seq.md
# barcode_seq

Sequencer for the iCE40UP barcode/IR current-sink driver. It owns the driver's three control inputs: current-reference enable, driver enable and PWM. From a single START it powers the current reference and waits out its settle time. It then enables the driver, serialises a latched bit pattern onto the PWM pin (one bit per programmable period, '1' bits modulated at a programmable duty), repeats the pattern if asked, and powers back down. It sits between the host register block and the hard driver primitive.

## Interface
- WARMUP_CYCLES, 1200: cycles CURREN is held before BARCODEEN rises (100 us at 12 MHz); must be ≥1.
- COOLDOWN_CYCLES, 16: cycles CURREN is held after BARCODEEN falls; must be ≥1.
- PAT_W, 32: pattern register width.

- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- START  in  1  request; sampled only in IDLE.
- ABORT  in  1  terminate the sequence immediately.
- PATTERN  in  PAT_W  bits to send, MSB first; latched on START.
- NBITS  in  clog2(PAT_W)+1  bits to send, 1..PAT_W; latched; 0 means START is ignored.
- BIT_PERIOD  in  16  cycles per bit; latched; 0 is treated as 1.
- DUTY  in  8  PWM high count per 256-cycle frame for '1' bits; latched.
- REPEAT  in  4  extra replays of the pattern (0 = send once); latched.
- BUSY  out  1  high in any state other than IDLE.
- DONE  out  1  one-cycle pulse on normal completion.
- CURREN  out  1  to the driver's CURREN.
- BARCODEEN  out  1  to the driver's BARCODEEN.
- BARCODEPWM  out  1  to the driver's BARCODEPWM.

## Operation
- States: IDLE → WARMUP → ENABLE → SEND → COOLDOWN → IDLE.
- IDLE: all outputs 0. START=1 with NBITS≠0 and ABORT=0 latches all inputs and moves to WARMUP.
- WARMUP: CURREN=1. A down-counter is loaded with WARMUP_CYCLES−1; the state moves to ENABLE when the counter reaches 0.
- ENABLE: exactly 1 cycle. CURREN=1, BARCODEEN=1, PWM=0.
- SEND: CURREN=1, BARCODEEN=1.
  - The current bit is the shift-register MSB. It is held for BIT_PERIOD cycles, then the register shifts left and the bit counter decrements.
  - An 8-bit pwm_cnt restarts at 0 on every bit boundary.
  - BARCODEPWM = bit & (pwm_cnt < DUTY). DUTY=0 gives a constant low; the signal is registered.
  - After bit NBITS: if the remaining repeat count is non-zero, decrement it, reload the shift register from the latched pattern and continue with no gap. Otherwise go to COOLDOWN.
- COOLDOWN: CURREN=1, BARCODEEN=0, PWM=0 for COOLDOWN_CYCLES cycles, then IDLE with DONE=1 for that first IDLE cycle.
- ABORT=1 in any non-IDLE state: the next cycle is IDLE with all outputs 0 and no DONE pulse. ABORT overrides every other condition.
- START while BUSY: ignored. Latched values never change mid-sequence.
- Invariants:
  - BARCODEEN=1 implies CURREN=1 (and CURREN rose ≥WARMUP_CYCLES earlier).
  - BARCODEPWM=1 implies BARCODEEN=1.

## Timing
- All outputs are registered. Reset forces IDLE: CURREN=BARCODEEN=BARCODEPWM=BUSY=DONE=0 and all counters 0.
- Reset mid-sequence behaves as ABORT, taking effect on the next edge.
- START sampled at edge 0 gives:
  - cycles 1..W: WARMUP
  - cycle W+1: ENABLE
  - cycles W+2 .. W+1+S: SEND, where S = NBITS·max(BIT_PERIOD,1)·(REPEAT+1)
  - next C cycles: COOLDOWN
  - following cycle: DONE=1, BUSY=0.
- BUSY is high from cycle 1 through the last COOLDOWN cycle.
- A new START is accepted in the DONE cycle.
- Bit k (0-based, counted across repeats) first appears on BARCODEPWM at cycle W+2+k·P.
- PWM frame wrap: pwm_cnt wraps 255→0 inside long bits, so a bit lasting more than 256 cycles repeats the duty pattern.

## Test plan
- W=8, C=4, PATTERN=0xA000_0000, NBITS=4, BIT_PERIOD=3, DUTY=255, REPEAT=0 → CURREN 1..25, BARCODEEN 9..21, PWM high at cycles 10–12 and 16–18 only, DONE at cycle 26.
- Same setup with REPEAT=2 → pattern 1010 appears three times back-to-back with no gap, SEND spans 36 cycles, DONE at cycle 50.
- Duty check: NBITS=1, PATTERN MSB=1, BIT_PERIOD=512, DUTY=64 → PWM high for cycles 0–63 and 256–319 of the bit (counted from bit start), 128 high cycles total. DUTY=0 → PWM never high.
- ABORT asserted in the 3rd SEND cycle → next cycle all outputs 0, BUSY=0, no DONE. START two cycles later is accepted normally.
- Edge inputs:
  - NBITS=0 with START → stays IDLE, BUSY=0.
  - BIT_PERIOD=0 → behaves as 1.
  - START pulsed during WARMUP → ignored; the sequence length is unchanged.
  - START and ABORT together in IDLE → stays IDLE.
- RST asserted in WARMUP and in SEND → all outputs 0 on the next edge. A bench assertion checks the BARCODEEN→CURREN and PWM→BARCODEEN invariants every cycle in all tests.
